key_debounce_fsm: RTL and testbench

Front-end conditioner for one raw push-button of the watch board. It synchronizes the asynchronous active-low key input, debounces it, and classifies each press into single-cycle event pulses: first-press, short-press, long-press and auto-repeat. These pulses feed the watch/stopwatch mode FSM and the time-setting logic. The design uses one instance per key.

---
 rtl/watch_pkg.sv | 22 ++
 rtl/key_sync.sv | 35 +++
 rtl/key_debounce_fsm.sv | 188 ++++++++++++++++++
 tb/tb_key_debounce_fsm.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// Shared types and helpers for the watch board front-end and prescalers.
//
// Contents:
//   key_state_t  - state encoding for key_debounce_fsm
//   ms_to_cycles - converts a millisecond interval to clock cycles
package watch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    HELD,
    LONG,
    DEB_REL
  } key_state_t;

  // Divide first so large clock rates do not overflow 32 bits.
  function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                               input int unsigned ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/key_sync.sv
// N-flop synchronizer for a single asynchronous bit.
//
// Ports:
//   clk     - destination clock
//   rst     - synchronous active-high reset
//   rst_val - value loaded into every flop while rst is high
//   d       - asynchronous input
//   q       - synchronized output (N clk cycles of latency)
module key_sync #(
  parameter int unsigned N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic d,
  output logic q
);

  if (N < 2) begin : g_bad_depth
    $error("key_sync: N must be at least 2");
  end

  logic [N-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {N{rst_val}};
    end else begin
      sync_q <= {sync_q[N-2:0], d};
    end
  end

  assign q = sync_q[N-1];

endmodule

// File: rtl/key_debounce_fsm.sv
// Push-button conditioner: synchronizes the active-low raw key, debounces
// both edges and classifies each press into one-cycle event pulses.
//
// Parameters:
//   CLK_HZ      - clock frequency in Hz
//   DEBOUNCE_MS - stable time required before an edge is accepted
//   LONG_MS     - hold time from press acceptance to key_long
//   REPEAT_MS   - auto-repeat period after key_long (0 disables repeat)
//
// Ports:
//   clk        - system clock
//   rst        - synchronous active-high reset
//   key_n      - raw button, active-low, asynchronous
//   key_level  - debounced level, 1 = pressed
//   key_first  - pulse when a press is accepted
//   key_short  - pulse when a press is released before key_long
//   key_long   - pulse once per press after the long hold time
//   key_repeat - pulse every repeat period after key_long while held
module key_debounce_fsm
  import watch_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned DEBOUNCE_MS = 10,
  parameter int unsigned LONG_MS     = 1000,
  parameter int unsigned REPEAT_MS   = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic key_level,
  output logic key_first,
  output logic key_short,
  output logic key_long,
  output logic key_repeat
);

  localparam int unsigned DEB_CYC  = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int unsigned LONG_CYC = ms_to_cycles(CLK_HZ, LONG_MS);
  localparam int unsigned REP_CYC  = ms_to_cycles(CLK_HZ, REPEAT_MS);
  localparam int unsigned MAX_CYC  = (LONG_CYC > REP_CYC) ? LONG_CYC : REP_CYC;
  localparam int unsigned CNT_W    = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
  localparam bit          REP_EN   = (REP_CYC > 0);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_EN ? REP_CYC - 1 : 0);

  if (DEB_CYC < 2 || LONG_CYC <= DEB_CYC) begin : g_bad_params
    $error("key_debounce_fsm: need DEB_CYC >= 2 and LONG_CYC > DEB_CYC");
  end

  // ---------------------------------------------------------------------
  // Input synchronizer; inversion happens ahead of the first flop so the
  // whole chain carries the active-high pressed level.
  // ---------------------------------------------------------------------
  logic sync_press;

  key_sync #(
    .N(2)
  ) u_key_sync (
    .clk     (clk),
    .rst     (rst),
    .rst_val (1'b0),
    .d       (~key_n),
    .q       (sync_press)
  );

  // ---------------------------------------------------------------------
  // State, shared counter and registered outputs
  // ---------------------------------------------------------------------
  key_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             long_seen_q, long_seen_d;
  logic             level_q, level_d;
  logic             first_q, first_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             rep_q, rep_d;

  logic             cnt_run;
  logic             cnt_wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      long_seen_q <= 1'b0;
      level_q     <= 1'b0;
      first_q     <= 1'b0;
      short_q     <= 1'b0;
      long_q      <= 1'b0;
      rep_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      long_seen_q <= long_seen_d;
      level_q     <= level_d;
      first_q     <= first_d;
      short_q     <= short_d;
      long_q      <= long_d;
      rep_q       <= rep_d;
    end
  end

  // A falling sync_press always wins over a counter match in the same
  // cycle, so a release is never turned into a late long/repeat event.
  always_comb begin
    state_d     = state_q;
    long_seen_d = long_seen_q;
    first_d     = 1'b0;
    short_d     = 1'b0;
    long_d      = 1'b0;
    rep_d       = 1'b0;
    cnt_run     = 1'b1;
    cnt_wrap    = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_run = 1'b0;
        if (sync_press) begin
          state_d = DEB_PRESS;
        end
      end

      DEB_PRESS: begin
        if (!sync_press) begin
          state_d = IDLE;
        end else if (cnt_q == DEB_LAST) begin
          state_d = HELD;
          first_d = 1'b1;
        end
      end

      HELD: begin
        if (!sync_press) begin
          state_d     = DEB_REL;
          long_seen_d = 1'b0;
        end else if (cnt_q == LONG_LAST) begin
          state_d = LONG;
          long_d  = 1'b1;
        end
      end

      LONG: begin
        if (!sync_press) begin
          state_d     = DEB_REL;
          long_seen_d = 1'b1;
        end else if (REP_EN) begin
          if (cnt_q == REP_LAST) begin
            rep_d    = 1'b1;
            cnt_wrap = 1'b1;
          end
        end else begin
          cnt_run = 1'b0;
        end
      end

      DEB_REL: begin
        // Re-press returns to the hold phase with its timing restarted.
        if (sync_press) begin
          state_d = long_seen_q ? LONG : HELD;
        end else if (cnt_q == DEB_LAST) begin
          state_d = IDLE;
          short_d = !long_seen_q;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    level_d = (state_d == HELD) || (state_d == LONG) || (state_d == DEB_REL);

    if ((state_d != state_q) || cnt_wrap || !cnt_run) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign key_level  = level_q;
  assign key_first  = first_q;
  assign key_short  = short_q;
  assign key_long   = long_q;
  assign key_repeat = rep_q;

endmodule

// File: tb/tb_key_debounce_fsm.sv
module tb_key_debounce_fsm;

  localparam int K_FIRST = 0;
  localparam int K_SHORT = 1;
  localparam int K_LONG  = 2;
  localparam int K_REP   = 3;
  localparam int K_UP    = 4;
  localparam int K_DN    = 5;

  logic clk = 1'b0;
  logic rst;
  logic key_n0, key_n1;
  logic lvl0, fst0, sht0, lng0, rep0;
  logic lvl1, fst1, sht1, lng1, rep1;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  key_debounce_fsm #(
    .CLK_HZ      (1000),
    .DEBOUNCE_MS (4),
    .LONG_MS     (20),
    .REPEAT_MS   (5)
  ) dut0 (
    .clk        (clk),
    .rst        (rst),
    .key_n      (key_n0),
    .key_level  (lvl0),
    .key_first  (fst0),
    .key_short  (sht0),
    .key_long   (lng0),
    .key_repeat (rep0)
  );

  key_debounce_fsm #(
    .CLK_HZ      (1000),
    .DEBOUNCE_MS (4),
    .LONG_MS     (20),
    .REPEAT_MS   (0)
  ) dut1 (
    .clk        (clk),
    .rst        (rst),
    .key_n      (key_n1),
    .key_level  (lvl1),
    .key_first  (fst1),
    .key_short  (sht1),
    .key_long   (lng1),
    .key_repeat (rep1)
  );

  typedef struct {
    int unit;
    int kind;
    int cyc;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;
  logic prev_lvl [2];
  logic [4:0] mon_o;
  logic [5:0] mon_ev;

  function automatic string kname(input int k);
    case (k)
      K_FIRST: return "first";
      K_SHORT: return "short";
      K_LONG:  return "long";
      K_REP:   return "repeat";
      K_UP:    return "level_rise";
      K_DN:    return "level_fall";
      default: return "unknown";
    endcase
  endfunction

  task automatic expect_evt(input int u, input int k, input int c);
    exp_t e;
    e.unit = u;
    e.kind = k;
    e.cyc  = c;
    sbq.push_back(e);
  endtask

  task automatic check_evt(input int u, input int k);
    exp_t e;
    tests++;
    if (sbq.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: got unit%0d %s at cycle %0d, required no event",
               u, kname(k), cyc);
    end else begin
      e = sbq.pop_front();
      if (e.unit != u || e.kind != k || e.cyc != cyc) begin
        fails++;
        $display("FAIL event_order: got unit%0d %s at cycle %0d, required unit%0d %s at cycle %0d",
                 u, kname(k), cyc, e.unit, kname(e.kind), e.cyc);
      end
    end
  endtask

  // Monitor: turns every output pulse / level edge into an event and
  // matches it against the head of the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int u = 0; u < 2; u++) begin
        mon_o = (u == 0) ? {lvl0, fst0, sht0, lng0, rep0}
                         : {lvl1, fst1, sht1, lng1, rep1};
        mon_ev[K_FIRST] = mon_o[3];
        mon_ev[K_SHORT] = mon_o[2];
        mon_ev[K_LONG]  = mon_o[1];
        mon_ev[K_REP]   = mon_o[0];
        mon_ev[K_UP]    = mon_o[4] && !prev_lvl[u];
        mon_ev[K_DN]    = !mon_o[4] && prev_lvl[u];
        prev_lvl[u]     = mon_o[4];
        for (int k = 0; k < 6; k++) begin
          if (mon_ev[k]) check_evt(u, k);
        end
      end
    end
  end

  task automatic wait_to(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_idle(input int u, input logic [4:0] got);
    tests++;
    if (got !== 5'b0) begin
      fails++;
      $display("FAIL reset_outputs unit%0d: got %b, required 00000", u, got);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    rst    = 1'b1;
    key_n0 = 1'b1;
    key_n1 = 1'b1;
    wait_to(3);
    rst = 1'b0;
    check_idle(0, {lvl0, fst0, sht0, lng0, rep0});
    check_idle(1, {lvl1, fst1, sht1, lng1, rep1});
    prev_lvl[0] = 1'b0;
    prev_lvl[1] = 1'b0;
    mon_en = 1'b1;

    // Clean 10-cycle press.
    t0 = cyc + 2;
    expect_evt(0, K_FIRST, t0 + 7);
    expect_evt(0, K_UP,    t0 + 7);
    expect_evt(0, K_SHORT, t0 + 17);
    expect_evt(0, K_DN,    t0 + 17);
    wait_to(t0);      key_n0 = 1'b0;
    wait_to(t0 + 10); key_n0 = 1'b1;
    wait_to(t0 + 30);

    // Press bounce: low 2, high 1, then stable low.
    t0 = cyc + 2;
    expect_evt(0, K_FIRST, t0 + 10);
    expect_evt(0, K_UP,    t0 + 10);
    expect_evt(0, K_SHORT, t0 + 20);
    expect_evt(0, K_DN,    t0 + 20);
    wait_to(t0);      key_n0 = 1'b0;
    wait_to(t0 + 2);  key_n0 = 1'b1;
    wait_to(t0 + 3);  key_n0 = 1'b0;
    wait_to(t0 + 13); key_n0 = 1'b1;
    wait_to(t0 + 35);

    // 1-cycle and 3-cycle glitches: no events.
    t0 = cyc + 2;
    wait_to(t0);      key_n0 = 1'b0;
    wait_to(t0 + 1);  key_n0 = 1'b1;
    wait_to(t0 + 15); key_n0 = 1'b0;
    wait_to(t0 + 18); key_n0 = 1'b1;
    wait_to(t0 + 35);

    // 40-cycle hold: long, then repeats every 5 until release seen.
    t0 = cyc + 2;
    expect_evt(0, K_FIRST, t0 + 7);
    expect_evt(0, K_UP,    t0 + 7);
    expect_evt(0, K_LONG,  t0 + 27);
    expect_evt(0, K_REP,   t0 + 32);
    expect_evt(0, K_REP,   t0 + 37);
    expect_evt(0, K_REP,   t0 + 42);
    expect_evt(0, K_DN,    t0 + 47);
    wait_to(t0);      key_n0 = 1'b0;
    wait_to(t0 + 40); key_n0 = 1'b1;
    wait_to(t0 + 60);

    // Release bounce in HELD restarts the hold count.
    t0 = cyc + 2;
    expect_evt(0, K_FIRST, t0 + 7);
    expect_evt(0, K_UP,    t0 + 7);
    expect_evt(0, K_LONG,  t0 + 37);
    expect_evt(0, K_DN,    t0 + 45);
    wait_to(t0);      key_n0 = 1'b0;
    wait_to(t0 + 12); key_n0 = 1'b1;
    wait_to(t0 + 14); key_n0 = 1'b0;
    wait_to(t0 + 38); key_n0 = 1'b1;
    wait_to(t0 + 60);

    // Reset while in LONG with the key held throughout.
    t0 = cyc + 2;
    expect_evt(0, K_FIRST, t0 + 7);
    expect_evt(0, K_UP,    t0 + 7);
    expect_evt(0, K_LONG,  t0 + 27);
    expect_evt(0, K_DN,    t0 + 30);
    expect_evt(0, K_FIRST, t0 + 38);
    expect_evt(0, K_UP,    t0 + 38);
    expect_evt(0, K_SHORT, t0 + 52);
    expect_evt(0, K_DN,    t0 + 52);
    wait_to(t0);      key_n0 = 1'b0;
    wait_to(t0 + 29); rst = 1'b1;
    wait_to(t0 + 31); rst = 1'b0;
    wait_to(t0 + 45); key_n0 = 1'b1;
    wait_to(t0 + 70);

    // Repeat disabled: 60-cycle hold gives one long and no repeats.
    t0 = cyc + 2;
    expect_evt(1, K_FIRST, t0 + 7);
    expect_evt(1, K_UP,    t0 + 7);
    expect_evt(1, K_LONG,  t0 + 27);
    expect_evt(1, K_DN,    t0 + 67);
    wait_to(t0);      key_n1 = 1'b0;
    wait_to(t0 + 60); key_n1 = 1'b1;
    wait_to(t0 + 85);

    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL missing_events: %0d expected events never seen, first is unit%0d %s at cycle %0d",
               sbq.size(), sbq[0].unit, kname(sbq[0].kind), sbq[0].cyc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
